// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and constants for the register-file write controller
package regfile_ctrl_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic REQ_WB   = 1'b0;
    localparam logic REQ_MC   = 1'b1;
    localparam int   ZERO_REG = 0;

endpackage

// File: rtl/regfile_write_ctrl_rr_arb2.sv
// rtl/regfile_write_ctrl_rr_arb2.sv - two-input round-robin grant that owns the priority pointer
import regfile_ctrl_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr == REQ_MC) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // The pointer only moves on a contended, enabled cycle, so a lone requester never steals a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= REQ_WB;
        end else if (en && (&valid)) begin
            rr <= ~rr;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// rtl/regfile_write_ctrl.sv - shares the register-file write port between writeback and the multi-cycle unit
import regfile_ctrl_pkg::*;

module regfile_write_ctrl #(
    parameter int AWL = 5,
    parameter int DWL = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           req0_valid,
    input  logic [AWL-1:0] req0_addr,
    input  logic [DWL-1:0] req0_data,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [AWL-1:0] req1_addr,
    input  logic [DWL-1:0] req1_data,
    output logic           req1_ready,
    output logic           rf_wen,
    output logic [AWL-1:0] rf_wa,
    output logic [DWL-1:0] rf_wd,
    output logic           busy,
    output logic           last_gnt
);

    state_t         state;
    logic [AWL-1:0] cnt;
    logic [1:0]     gnt;
    logic           arb_en;
    logic           sel;
    logic [AWL-1:0] sel_addr;
    logic [DWL-1:0] sel_data;

    assign arb_en = (state == RUN) && !clr;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid ({req1_valid, req0_valid}),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign busy       = (state == FILL);

    assign sel      = gnt[1] ? REQ_MC : REQ_WB;
    assign sel_addr = gnt[1] ? req1_addr : req0_addr;
    assign sel_data = gnt[1] ? req1_data : req0_data;

    // Distributed RAM has no reset, so every register except $0 is walked to zero first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            cnt      <= AWL'(1);
            rf_wen   <= 1'b0;
            rf_wa    <= '0;
            rf_wd    <= '0;
            last_gnt <= REQ_WB;
        end else if (clr) begin
            state  <= FILL;
            cnt    <= AWL'(1);
            rf_wen <= 1'b0;
        end else if (state == FILL) begin
            rf_wen <= 1'b1;
            rf_wa  <= cnt;
            rf_wd  <= '0;
            if (cnt == {AWL{1'b1}}) begin
                state <= RUN;
                cnt   <= AWL'(1);
            end else begin
                cnt <= cnt + AWL'(1);
            end
        end else if (|gnt) begin
            last_gnt <= sel;
            if (sel_addr != AWL'(ZERO_REG)) begin
                rf_wen <= 1'b1;
                rf_wa  <= sel_addr;
                rf_wd  <= sel_data;
            end else begin
                rf_wen <= 1'b0;
            end
        end else begin
            rf_wen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb/tb_regfile_write_ctrl.sv - scoreboard bench for regfile_write_ctrl
module tb_regfile_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        busy;
    logic        last_gnt;

    regfile_write_ctrl #(.AWL(5), .DWL(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_wen     (rf_wen),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .busy       (busy),
        .last_gnt   (last_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        last;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    logic       m_run;
    logic [4:0] m_cnt;
    logic       m_rr;
    logic       m_last;
    logic [4:0] m_wa;
    logic [31:0] m_wd;
    logic       m_g0;
    logic       m_g1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 5'd1;
        m_rr   = 1'b0;
        m_last = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_g0   = 1'b0;
        m_g1   = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wen"}, 64'(rf_wen), 64'd0);
        check_eq({tag, "_wa"}, 64'(rf_wa), 64'd0);
        check_eq({tag, "_wd"}, 64'(rf_wd), 64'd0);
        check_eq({tag, "_last"}, 64'(last_gnt), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        check_eq({tag, "_rdy0"}, 64'(req0_ready), 64'd0);
        check_eq({tag, "_rdy1"}, 64'(req1_ready), 64'd0);
    endtask

    // Called just after a falling edge: drive, check ready, predict the next edge, then compare.
    task automatic tick(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic c);
        exp_t       e;
        logic       en;
        logic [4:0] addr;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        clr        = c;
        #1;
        en   = m_run && !c;
        m_g0 = en && v0 && (!v1 || !m_rr);
        m_g1 = en && v1 && (!v0 || m_rr);
        check_eq("ready0", 64'(req0_ready), 64'(m_g0));
        check_eq("ready1", 64'(req1_ready), 64'(m_g1));
        e.wen = 1'b0;
        if (c) begin
            m_run = 1'b0;
            m_cnt = 5'd1;
        end else if (!m_run) begin
            e.wen = 1'b1;
            m_wa  = m_cnt;
            m_wd  = '0;
            if (m_cnt == 5'd31) m_run = 1'b1;
            m_cnt = (m_cnt == 5'd31) ? 5'd1 : m_cnt + 5'd1;
        end else if (m_g0 || m_g1) begin
            m_last = m_g1;
            if (v0 && v1) m_rr = !m_rr;
            addr = m_g1 ? a1 : a0;
            if (addr != 5'd0) begin
                e.wen = 1'b1;
                m_wa  = addr;
                m_wd  = m_g1 ? d1 : d0;
            end
        end
        e.wa   = m_wa;
        e.wd   = m_wd;
        e.last = m_last;
        e.busy = !m_run;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check_eq("rf_wen", 64'(rf_wen), 64'(e.wen));
        check_eq("rf_wa", 64'(rf_wa), 64'(e.wa));
        check_eq("rf_wd", 64'(rf_wd), 64'(e.wd));
        check_eq("last_gnt", 64'(last_gnt), 64'(e.last));
        check_eq("busy", 64'(busy), 64'(e.busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    logic        r0v, r1v, rc;
    logic [4:0]  r0a, r1a;
    logic [31:0] r0d, r1d;

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Power-up fill of 1..31, then one idle RUN cycle.
        idle(31);
        idle(1);

        tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);

        for (int i = 0; i < 4; i++)
            tick(1'b1, 5'd3, 32'h3333_0000 + 32'(i), 1'b1, 5'd7, 32'h7777_0000 + 32'(i), 1'b0);

        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
        idle(1);

        // clr while req0 waits; req0 is held through the refill and accepted afterwards.
        tick(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 31; i++) tick(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 1'b0);
        idle(1);

        r0v = 1'b0;
        r1v = 1'b0;
        r0a = '0;
        r1a = '0;
        r0d = '0;
        r1d = '0;
        for (int i = 0; i < 80; i++) begin
            if (!(r0v && !m_g0)) begin
                r0v = 1'($urandom_range(0, 1));
                r0a = 5'($urandom);
                r0d = $urandom;
            end
            if (!(r1v && !m_g1)) begin
                r1v = 1'($urandom_range(0, 1));
                r1a = 5'($urandom);
                r1d = $urandom;
            end
            rc = ($urandom_range(0, 29) == 0);
            tick(r0v, r0a, r0d, r1v, r1a, r1d, rc);
        end

        // Restart fill, then pull reset when address 12 is on the port.
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(12);
        check_eq("midfill_wa", 64'(rf_wa), 64'd12);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midfill_rst");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle(31);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the MIPS register file. It shares the file's single write port between two requesters: requester 0 is pipeline writeback, requester 1 is the multi-cycle unit (mult/div, load-miss return). Arbitration is round-robin with valid/ready handshakes. The block also runs a zero-fill sequence after reset and on demand, because distributed-RAM contents cannot be reset. It drops every write to register $0 and registers all write-port outputs.

## Interface
- AWL, 5, register address width; register count is 2^AWL.
- DWL, 32, data width.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  one-cycle request to re-run the zero-fill sequence.
- req0_valid  in  1  writeback write request.
- req0_addr  in  AWL  writeback destination register.
- req0_data  in  DWL  writeback data.
- req0_ready  out  1  writeback request accepted this cycle.
- req1_valid / req1_addr / req1_data / req1_ready  same as port 0, for the multi-cycle unit.
- rf_wen  out  1  register file write enable.
- rf_wa  out  AWL  register file write address.
- rf_wd  out  DWL  register file write data.
- busy  out  1  high while zero-fill runs.
- last_gnt  out  1  requester id of the most recent accepted request.

## Operation
- States: FILL and RUN. Reset enters FILL.
- FILL:
  - Internal counter cnt starts at 1.
  - Each edge: rf_wen<=1, rf_wa<=cnt, rf_wd<=0, cnt<=cnt+1.
  - When cnt == 2^AWL-1 is issued, the state moves to RUN.
  - Address 0 is never written.
- RUN: arbitration.
  - Exactly one valid requester: it is granted.
  - Both valid: the requester named by pointer rr is granted; rr flips to the other requester.
  - No contention: rr is unchanged.
- reqN_ready = (state==RUN) && !clr && granted(N). Ready is combinational from valid, rr, state and clr.
- Acceptance = valid && ready at the edge. Data and address must stay stable while valid is high and ready is low.
- Accepted request with addr != 0: next edge sets rf_wen<=1, rf_wa<=addr, rf_wd<=data.
- Accepted request with addr == 0: the request is consumed, but rf_wen<=0 (dropped).
- No acceptance: rf_wen<=0; rf_wa and rf_wd hold their previous values.
- clr in RUN:
  - Forces ready low in that cycle.
  - Next edge enters FILL with cnt=1.
- clr in FILL: cnt restarts at 1 on the next edge.
- busy = (state==FILL).

## Timing
- Reset values:
  - rf_wen=0, rf_wa=0, rf_wd=0, last_gnt=0.
  - busy=1, state=FILL, cnt=1, rr=0.
  - reqN_ready=0.
- Fill timing after rst_n deasserts:
  - Edge 1 issues address 1; edge 31 issues address 31 (for AWL=5).
  - The state is RUN after edge 31, so ready can assert in the following cycle.
  - Fill takes 2^AWL-1 cycles.
- Write latency: the write is visible on rf_* one cycle after acceptance. The register file read sees the new value in the cycle after that edge; bypass is the hazard unit's job.
- Throughput: one write per cycle. A losing requester waits at most one cycle under continuous contention.
- rst_n asserted mid-fill or mid-write: all state returns immediately to reset values. No partial write is held.

## Structure
- Package regfile_ctrl_pkg holds:
  - state typedef (FILL, RUN);
  - requester id constants REQ_WB=0 and REQ_MC=1;
  - constant ZERO_REG=0.
- Sub-module rr_arb2: a two-input round-robin grant with pointer update. Inputs: valid[1:0], en. Outputs: gnt[1:0]. It owns rr.
- Everything else (fill counter, output registers) lives in the top module.

## Test plan
- Reset release, no requests: rf_wen high for 31 consecutive cycles with rf_wa stepping 1..31 and rf_wd=0. Then busy=0 and rf_wen=0.
- RUN, req0 only, addr=5, data=0xDEADBEEF: ready0=1 the same cycle; next cycle rf_wen=1, rf_wa=5, rf_wd=0xDEADBEEF.
- Both valid for 4 cycles (req0 addr=3, req1 addr=7), rr=0: grants alternate 0,1,0,1; rf_wa sequence is 3,7,3,7; last_gnt toggles.
- req1 addr=0, data=0x1234 in RUN: ready1=1 and the request is consumed; the next cycle has rf_wen=0.
- clr pulsed while req0 is valid: ready0=0 that cycle. The next 31 cycles zero-fill with busy=1; req0 is accepted in the first RUN cycle.
- rst_n pulled low mid-fill, at rf_wa=12: outputs return to reset values immediately. After release the fill restarts at address 1.
